// File: rtl/fm_demod_pkg.sv
// fm_demod_pkg
// Shared types and helpers for the FM quadrature demodulator:
//   state_t   - demodulator FSM states
//   deq()     - fixed-point rescale (arithmetic shift, round toward zero)
//   *_DEF     - default gain/quadrant constants in Q10
package fm_demod_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MIX,
    PREP,
    DIV,
    ANGLE,
    OUT
  } state_t;

  localparam int GAIN_DEF         = 758;
  localparam int QUAD1_DEF        = 804;
  localparam int QUAD3_DEF        = 2412;
  localparam int DEEMPH_SHIFT_DEF = 3;

  // Callers sign-extend into 64 bits and slice the result back down, so one
  // helper serves every datapath width up to 64.
  function automatic logic signed [63:0] deq(input logic signed [63:0] x,
                                              input int bits);
    logic signed [63:0] bias;
    bias = x[63] ? ((64'sd1 <<< bits) - 64'sd1) : 64'sd0;
    return (x + bias) >>> bits;
  endfunction

endpackage

// File: rtl/fm_demod_pipe_div.sv
// fm_div_iter
// Signed restoring divider, one quotient bit per cycle; quotient truncates
// toward zero. The first bit is resolved on the start edge, so div_done
// pulses exactly DATA_WIDTH cycles after div_start with q already valid.
// A zero divisor yields q = 0.
// Ports:
//   clock, reset            - clock, synchronous active-high reset
//   div_start               - load operands and begin (ignored while busy)
//   dividend, divisor       - signed operands, sampled with div_start
//   q                       - signed quotient, held until the next start
//   div_done                - one-cycle completion pulse
//   busy                    - iteration in progress
module fm_div_iter
  import fm_demod_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         div_start,
  input  logic signed [DATA_WIDTH-1:0] dividend,
  input  logic signed [DATA_WIDTH-1:0] divisor,
  output logic signed [DATA_WIDTH-1:0] q,
  output logic                         div_done,
  output logic                         busy
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]         cnt_q;
  logic                  neg_q, zero_q;

  logic [DATA_WIDTH-1:0] mag_dvd, mag_dvs;
  logic [DATA_WIDTH-1:0] src_rem, src_quo, src_dvs;
  logic [DATA_WIDTH:0]   shifted, trial;
  logic [DATA_WIDTH-1:0] rem_nxt, quo_nxt;

  always_comb begin
    mag_dvd = dividend[DATA_WIDTH-1] ? -dividend : dividend;
    mag_dvs = divisor[DATA_WIDTH-1]  ? -divisor  : divisor;
    src_rem = div_start ? '0      : rem_q;
    src_quo = div_start ? mag_dvd : quo_q;
    src_dvs = div_start ? mag_dvs : dvs_q;
    // remainder stays below the divisor, so shifted never exceeds DATA_WIDTH+1 bits
    shifted = {src_rem, src_quo[DATA_WIDTH-1]};
    trial   = shifted - {1'b0, src_dvs};
    if (!trial[DATA_WIDTH]) begin
      rem_nxt = trial[DATA_WIDTH-1:0];
      quo_nxt = {src_quo[DATA_WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = shifted[DATA_WIDTH-1:0];
      quo_nxt = {src_quo[DATA_WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      busy     <= 1'b0;
      div_done <= 1'b0;
    end else begin
      div_done <= 1'b0;
      if (div_start && !busy) begin
        rem_q  <= rem_nxt;
        quo_q  <= quo_nxt;
        dvs_q  <= mag_dvs;
        neg_q  <= dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1];
        zero_q <= (divisor == '0);
        cnt_q  <= CW'(DATA_WIDTH - 1);
        busy   <= 1'b1;
      end else if (busy) begin
        rem_q <= rem_nxt;
        quo_q <= quo_nxt;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          busy     <= 1'b0;
          div_done <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    if (zero_q)     q = '0;
    else if (neg_q) q = -$signed(quo_q);
    else            q = $signed(quo_q);
  end

endmodule

// File: rtl/fm_demod_pipe.sv
// fm_demod_pipe
// FM quadrature demodulator: pops one I/Q pair, mixes it with the conjugate
// of the previous pair, approximates the phase step with a rational
// arctangent (via fm_div_iter), scales by GAIN and pushes one audio sample.
// One sample in flight; a new pair is accepted DATA_WIDTH+5 cycles apart.
// Ports:
//   clock, reset        - clock, synchronous active-high reset
//   I_dout/I_empty/I_rd_en - in-phase FIFO read side
//   Q_dout/Q_empty/Q_rd_en - quadrature FIFO read side
//   out_din/out_full/out_wr_en - output FIFO write side (out_din = 0 when idle)
// Build option: FM_DEMOD_DEEMPH_EN adds a first-order de-emphasis IIR
// (coefficient 2^-DEEMPH_SHIFT) on the output samples.
//
// state | meaning
// IDLE  | wait for both FIFOs non-empty; pop, form partial products, update history
// MIX   | combine partial products into r (real) and i (imag)
// PREP  | form rational-arctan dividend/divisor, start divider
// DIV   | wait for divider completion
// ANGLE | map quotient to angle, apply gain, register y
// OUT   | push y when the output FIFO has room
module fm_demod_pipe
  import fm_demod_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BITS       = 10,
  parameter int GAIN       = GAIN_DEF,
  parameter int QUAD1      = QUAD1_DEF,
  parameter int QUAD3      = QUAD3_DEF
`ifdef FM_DEMOD_DEEMPH_EN
  , parameter int DEEMPH_SHIFT = DEEMPH_SHIFT_DEF
`endif
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] I_dout,
  input  logic                  I_empty,
  output logic                  I_rd_en,
  input  logic [DATA_WIDTH-1:0] Q_dout,
  input  logic                  Q_empty,
  output logic                  Q_rd_en,
  output logic [DATA_WIDTH-1:0] out_din,
  input  logic                  out_full,
  output logic                  out_wr_en
);

  typedef logic signed [DATA_WIDTH-1:0] sword_t;

  localparam sword_t GAIN_W  = sword_t'(GAIN);
  localparam sword_t QUAD1_W = sword_t'(QUAD1);
  localparam sword_t QUAD3_W = sword_t'(QUAD3);

  function automatic sword_t deq_w(input sword_t x);
    logic signed [63:0] t;
    t = deq(64'(x), BITS);
    return t[DATA_WIDTH-1:0];
  endfunction

  state_t state, state_nxt;
  logic   rst_done;    // keeps the FIFO pops off for the first cycle after reset
  sword_t prev_r, prev_i;
  sword_t p_rr, p_qi, p_qr, p_ii;
  sword_t r_q, i_q, y_q;

  logic   div_start, div_done, div_busy;
  sword_t div_q;
  sword_t i_s, q_s, abs_i, dividend, divisor, angle, y_nxt, out_val;

  always_comb begin
    i_s   = $signed(I_dout);
    q_s   = $signed(Q_dout);
    abs_i = ((i_q < 0) ? -i_q : i_q) + sword_t'(1);
    if (r_q >= 0) begin
      dividend = (r_q - abs_i) <<< BITS;
      divisor  = r_q + abs_i;
    end else begin
      dividend = (r_q + abs_i) <<< BITS;
      divisor  = abs_i - r_q;
    end
    angle = ((r_q >= 0) ? QUAD1_W : QUAD3_W) - deq_w(QUAD1_W * div_q);
    if (i_q < 0) angle = -angle;
    y_nxt = deq_w(GAIN_W * angle);
  end

  always_comb begin
    state_nxt = state;
    I_rd_en   = 1'b0;
    Q_rd_en   = 1'b0;
    div_start = 1'b0;
    out_wr_en = 1'b0;
    case (state)
      IDLE: begin
        if (rst_done && !I_empty && !Q_empty && !div_busy) begin
          I_rd_en   = 1'b1;
          Q_rd_en   = 1'b1;
          state_nxt = MIX;
        end
      end
      MIX:  state_nxt = PREP;
      PREP: begin
        div_start = 1'b1;
        state_nxt = DIV;
      end
      DIV:   if (div_done) state_nxt = ANGLE;
      ANGLE: state_nxt = OUT;
      OUT: begin
        if (!out_full) begin
          out_wr_en = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      rst_done <= 1'b0;
      prev_r   <= '0;
      prev_i   <= '0;
      p_rr     <= '0;
      p_qi     <= '0;
      p_qr     <= '0;
      p_ii     <= '0;
      r_q      <= '0;
      i_q      <= '0;
      y_q      <= '0;
    end else begin
      state    <= state_nxt;
      rst_done <= 1'b1;
      if (I_rd_en) begin
        p_rr   <= deq_w(i_s * prev_r);
        p_qi   <= deq_w(q_s * prev_i);
        p_qr   <= deq_w(q_s * prev_r);
        p_ii   <= deq_w(i_s * prev_i);
        prev_r <= i_s;
        prev_i <= q_s;
      end
      if (state == MIX) begin
        r_q <= p_rr + p_qi;
        i_q <= p_qr - p_ii;
      end
      if (state == ANGLE) y_q <= y_nxt;
    end
  end

`ifdef FM_DEMOD_DEEMPH_EN
  sword_t d_q;

  always_comb out_val = d_q + ((y_q - d_q) >>> DEEMPH_SHIFT);

  always_ff @(posedge clock) begin
    if (reset)          d_q <= '0;
    else if (out_wr_en) d_q <= out_val;
  end
`else
  always_comb out_val = y_q;
`endif

  assign out_din = out_wr_en ? out_val : '0;

  fm_div_iter #(.DATA_WIDTH(DATA_WIDTH)) u_div (
    .clock    (clock),
    .reset    (reset),
    .div_start(div_start),
    .dividend (dividend),
    .divisor  (divisor),
    .q        (div_q),
    .div_done (div_done),
    .busy     (div_busy)
  );

endmodule

// File: tb/tb_fm_demod_pipe.sv
// tb_fm_demod_pipe
// Directed bench for fm_demod_pipe (DATA_WIDTH=32, BITS=10, de-emphasis off).
// Expected outputs are hand-computed from the rational-arctan formulas.
module tb_fm_demod_pipe;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] I_dout, Q_dout, out_din;
  logic        I_empty, Q_empty, I_rd_en, Q_rd_en;
  logic        out_full, out_wr_en;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  fm_demod_pipe dut (
    .clock    (clock),
    .reset    (reset),
    .I_dout   (I_dout),
    .I_empty  (I_empty),
    .I_rd_en  (I_rd_en),
    .Q_dout   (Q_dout),
    .Q_empty  (Q_empty),
    .Q_rd_en  (Q_rd_en),
    .out_din  (out_din),
    .out_full (out_full),
    .out_wr_en(out_wr_en)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one pair, wait for the pop, then for the write; checks pop pairing,
  // idle output, 36-cycle latency, value, and single-cycle write.
  task automatic run_sample(input logic signed [31:0] iv, input logic signed [31:0] qv,
                            input logic signed [31:0] exp, input string tag);
    int n;
    int lat;
    @(posedge clock); #1;
    I_dout = iv; Q_dout = qv; I_empty = 1'b0; Q_empty = 1'b0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!I_rd_en && n < 100);
    check({tag, "_rd_pair"}, {30'd0, I_rd_en, Q_rd_en}, 32'sd3);
    @(posedge clock); #1;
    I_empty = 1'b1; Q_empty = 1'b1;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clock);
      if (k == 1) check({tag, "_idle_out"}, out_din, 32'sd0);
      if (out_wr_en) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, lat, 32'sd36);
    check({tag, "_value"}, out_din, exp);
    @(negedge clock);
    check({tag, "_single_wr"}, {31'd0, out_wr_en}, 32'sd0);
  endtask

  initial begin
    int writes;
    int n;
    reset = 1'b1; out_full = 1'b0;
    I_dout = 32'sd1024; Q_dout = 32'sd0; I_empty = 1'b0; Q_empty = 1'b0;

    // reset: no pops or writes, even with both FIFOs holding data
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_rd", {30'd0, I_rd_en, Q_rd_en}, 32'sd0);
    check("rst_wr", {31'd0, out_wr_en}, 32'sd0);
    check("rst_din", out_din, 32'sd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_rd", {30'd0, I_rd_en, Q_rd_en}, 32'sd0);

    // first sample after reset: r=0,i=0 -> q=-1024, angle=1608 -> 1190
    run_sample(32'sd1024, 32'sd0, 32'sd1190, "s1");
    // +pi/2 steps
    run_sample(32'sd0, 32'sd1024, 32'sd1190, "s2");
    run_sample(-32'sd1024, 32'sd0, 32'sd1190, "s3");
    // from (-1024,0) to (1024,0): r=-1024 -> angle 3214 -> 2379
    run_sample(32'sd1024, 32'sd0, 32'sd2379, "s4");
    // from (1024,0) to (0,-1024): negative angle, round toward zero -> -1190
    run_sample(32'sd0, -32'sd1024, -32'sd1190, "s5");
    // from (0,-1024) to (1024,0): +pi/2 -> 1190
    run_sample(32'sd1024, 32'sd0, 32'sd1190, "s6");
    // from (1024,0) to (-1024,0): q=-1022, angle 3214 -> 2379
    run_sample(-32'sd1024, 32'sd0, 32'sd2379, "s7");

    // only one FIFO non-empty: no pop
    @(posedge clock); #1;
    I_empty = 1'b0; Q_empty = 1'b1;
    repeat (4) @(negedge clock);
    check("i_only_rd", {30'd0, I_rd_en, Q_rd_en}, 32'sd0);
    @(posedge clock); #1;
    I_empty = 1'b1; Q_empty = 1'b0;
    repeat (4) @(negedge clock);
    check("q_only_rd", {30'd0, I_rd_en, Q_rd_en}, 32'sd0);

    // stall: from (-1024,0) to (-1024,0): r=1024, q=1022, angle=2 -> y=1
    @(posedge clock); #1;
    out_full = 1'b1;
    I_dout = -32'sd1024; Q_dout = 32'sd0; I_empty = 1'b0; Q_empty = 1'b0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!I_rd_en && n < 100);
    check("stall_rd", {31'd0, I_rd_en}, 32'sd1);
    repeat (36) @(negedge clock);
    for (int k = 0; k < 10; k++) begin
      check("stall_hold", {30'd0, out_wr_en, I_rd_en}, 32'sd0);
      if (k < 9) @(negedge clock);
    end
    @(posedge clock); #1;
    out_full = 1'b0;
    @(negedge clock);
    check("stall_release_wr", {31'd0, out_wr_en}, 32'sd1);
    check("stall_value", out_din, 32'sd1);
    @(posedge clock); #1;
    I_empty = 1'b1; Q_empty = 1'b1;
    @(negedge clock);
    check("stall_single_wr", {30'd0, out_wr_en, I_rd_en}, 32'sd0);

    // reset mid-divide: in-flight sample is dropped, history cleared
    @(posedge clock); #1;
    I_dout = 32'sd1024; Q_dout = 32'sd0; I_empty = 1'b0; Q_empty = 1'b0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!I_rd_en && n < 100);
    check("abort_rd", {31'd0, I_rd_en}, 32'sd1);
    @(posedge clock); #1;
    I_empty = 1'b1; Q_empty = 1'b1;
    repeat (10) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("abort_rst_wr", {31'd0, out_wr_en}, 32'sd0);
    @(posedge clock); #1;
    reset = 1'b0;
    writes = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (out_wr_en) writes++;
    end
    check("abort_no_write", writes, 32'sd0);
    run_sample(32'sd1024, 32'sd0, 32'sd1190, "s8");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
